// File: rtl/modular_inverse_stream_if.sv
// Request/response channel of the streaming modular inverter.
interface modular_inverse_stream_if #(
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned TAG_WIDTH  = 8,
  parameter int unsigned CNT_WIDTH  = $clog2(4 * DATA_WIDTH + 1)
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_a;
  logic [DATA_WIDTH-1:0] in_p;
  logic [TAG_WIDTH-1:0]  in_tag;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_r;
  logic [1:0]            out_status;
  logic [TAG_WIDTH-1:0]  out_tag;
  logic [CNT_WIDTH-1:0]  out_iters;

  modport master (
    output in_valid, in_a, in_p, in_tag, out_ready,
    input  in_ready, out_valid, out_r, out_status, out_tag, out_iters
  );

  modport slave (
    input  in_valid, in_a, in_p, in_tag, out_ready,
    output in_ready, out_valid, out_r, out_status, out_tag, out_iters
  );
endinterface

// File: rtl/modular_inverse_stream.sv
// Streaming modular inverter: R = a^-1 mod p by binary extended Euclid, one step per cycle.
module modular_inverse_stream #(
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned TAG_WIDTH  = 8,
  parameter int unsigned MAX_ITER   = 4 * DATA_WIDTH,
  parameter int unsigned CNT_WIDTH  = $clog2(MAX_ITER + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          abort,
  output logic                          busy,
  modular_inverse_stream_if.slave       bus
);
  localparam int unsigned W = DATA_WIDTH;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StCheck = 2'd1;
  localparam logic [1:0] StRun   = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  localparam logic [1:0] StatOk      = 2'd0;
  localparam logic [1:0] StatNotInv  = 2'd1;
  localparam logic [1:0] StatBad     = 2'd2;
  localparam logic [1:0] StatTimeout = 2'd3;

  localparam logic [W-1:0]         One    = W'(1);
  localparam logic [W-1:0]         PMin   = W'(3);
  localparam logic [CNT_WIDTH-1:0] CntMax = CNT_WIDTH'(MAX_ITER);
  localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

  logic [1:0]           state_q, state_d;
  logic [W-1:0]         u_q, u_d, v_q, v_d, x_q, x_d, y_q, y_d, p_q, p_d, r_q, r_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [1:0]           status_q, status_d;

  // Halving and wrapped subtraction need one extra bit so x+p cannot overflow.
  logic [W:0] x_sum, y_sum, x_diff, y_diff;

  // Arithmetic helpers for the coefficient updates; both keep x, y in [0, p).
  always_comb begin
    x_sum  = x_q[0] ? ({1'b0, x_q} + {1'b0, p_q}) : {1'b0, x_q};
    y_sum  = y_q[0] ? ({1'b0, y_q} + {1'b0, p_q}) : {1'b0, y_q};
    x_diff = {1'b0, x_q} - {1'b0, y_q} + ((x_q >= y_q) ? '0 : {1'b0, p_q});
    y_diff = {1'b0, y_q} - {1'b0, x_q} + ((y_q >= x_q) ? '0 : {1'b0, p_q});
  end

  // Next-state logic: handshake, input check and one reduction rule per RUN cycle.
  always_comb begin
    state_d  = state_q;
    u_d      = u_q;
    v_d      = v_q;
    x_d      = x_q;
    y_d      = y_q;
    p_d      = p_q;
    r_d      = r_q;
    tag_d    = tag_q;
    cnt_d    = cnt_q;
    status_d = status_q;
    if (abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            u_d     = bus.in_a;
            v_d     = bus.in_p;
            x_d     = One;
            y_d     = '0;
            p_d     = bus.in_p;
            tag_d   = bus.in_tag;
            cnt_d   = '0;
            state_d = StCheck;
          end
        end
        StCheck: begin
          if (!p_q[0] || (p_q < PMin) || (u_q == '0)) begin
            status_d = StatBad;
            r_d      = '0;
            state_d  = StDone;
          end else begin
            state_d = StRun;
          end
        end
        StRun: begin
          if (u_q == One) begin
            r_d = x_q; status_d = StatOk; state_d = StDone;
          end else if (v_q == One) begin
            r_d = y_q; status_d = StatOk; state_d = StDone;
          end else if (cnt_q == CntMax) begin
            r_d = '0; status_d = StatTimeout; state_d = StDone;
          end else if (!u_q[0]) begin
            u_d = u_q >> 1; x_d = W'(x_sum >> 1); cnt_d = cnt_q + CntOne;
          end else if (!v_q[0]) begin
            v_d = v_q >> 1; y_d = W'(y_sum >> 1); cnt_d = cnt_q + CntOne;
          end else if (u_q == v_q) begin
            r_d = '0; status_d = StatNotInv; state_d = StDone;
          end else if (u_q > v_q) begin
            u_d = u_q - v_q; x_d = W'(x_diff); cnt_d = cnt_q + CntOne;
          end else begin
            v_d = v_q - u_q; y_d = W'(y_diff); cnt_d = cnt_q + CntOne;
          end
        end
        StDone: begin
          if (bus.out_ready) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      u_q      <= '0;
      v_q      <= '0;
      x_q      <= '0;
      y_q      <= '0;
      p_q      <= '0;
      r_q      <= '0;
      tag_q    <= '0;
      cnt_q    <= '0;
      status_q <= StatOk;
    end else begin
      state_q  <= state_d;
      u_q      <= u_d;
      v_q      <= v_d;
      x_q      <= x_d;
      y_q      <= y_d;
      p_q      <= p_d;
      r_q      <= r_d;
      tag_q    <= tag_d;
      cnt_q    <= cnt_d;
      status_q <= status_d;
    end
  end

  // Counter freezes once DONE is reached, so it doubles as the step-count output.
  assign bus.in_ready   = (state_q == StIdle);
  assign bus.out_valid  = (state_q == StDone);
  assign bus.out_r      = r_q;
  assign bus.out_status = status_q;
  assign bus.out_tag    = tag_q;
  assign bus.out_iters  = cnt_q;
  assign busy           = (state_q != StIdle);
endmodule

// File: tb/tb_modular_inverse_stream.sv
// Self-checking bench for modular_inverse_stream with a plain-arithmetic reference model.
module tb_modular_inverse_stream;
  localparam int unsigned DW = 256;
  localparam int unsigned CW = $clog2(4 * DW + 1);
  localparam int unsigned MaxIter = 4 * DW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic abort = 1'b0;
  logic t_abort = 1'b0;
  logic busy, t_busy;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  modular_inverse_stream_if #(.DATA_WIDTH(DW), .TAG_WIDTH(8), .CNT_WIDTH(CW)) bus ();
  modular_inverse_stream_if #(.DATA_WIDTH(DW), .TAG_WIDTH(8), .CNT_WIDTH(3)) tbus ();

  modular_inverse_stream #(.DATA_WIDTH(DW), .TAG_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .abort(abort), .busy(busy), .bus(bus)
  );

  modular_inverse_stream #(.DATA_WIDTH(DW), .TAG_WIDTH(8), .MAX_ITER(4)) dut_to (
    .clk(clk), .rst(rst), .abort(t_abort), .busy(t_busy), .bus(tbus)
  );

  function automatic logic [DW-1:0] rand256();
    logic [DW-1:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [DW-1:0] gcd(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] t;
    while (b != '0) begin
      t = a % b; a = b; b = t;
    end
    return a;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Drives one request, waits for the result, then completes the output handshake.
  task automatic run_job(input logic [DW-1:0] a, input logic [DW-1:0] p, input logic [7:0] tag,
                         output logic [DW-1:0] r, output logic [1:0] st, output logic [7:0] tg,
                         output logic [CW-1:0] it, output int lat, output bit got);
    bus.in_a = a; bus.in_p = p; bus.in_tag = tag; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    for (int i = 0; i < 50 && !bus.in_ready; i++) tick();
    tick();
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 3000) begin
      tick(); lat++;
    end
    got = bus.out_valid; r = bus.out_r; st = bus.out_status; tg = bus.out_tag; it = bus.out_iters;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if ({bus.in_ready, bus.out_valid, busy} !== 3'b100) begin
      n_bad++; $display("FAIL reset_flags: got %b want 100", {bus.in_ready, bus.out_valid, busy});
    end
    n_cmp++;
    if (bus.out_r !== '0 || bus.out_status !== 2'd0 || bus.out_tag !== 8'd0 || bus.out_iters !== '0)
    begin
      n_bad++; $display("FAIL reset_outputs: r=%h st=%0d tag=%h it=%0d want all 0",
                        bus.out_r, bus.out_status, bus.out_tag, bus.out_iters);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    logic [DW-1:0] ta[7] = '{256'd3, 256'd1, 256'd10, 256'd6, 256'd0, 256'd3, 256'd2};
    logic [DW-1:0] tp[7] = '{256'd7, 256'd7, 256'd7, 256'd9, 256'd7, 256'd8, 256'd1};
    logic [DW-1:0] tr[7] = '{256'd5, 256'd1, 256'd5, 256'd0, 256'd0, 256'd0, 256'd0};
    logic [1:0]    ts[7] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd2};
    int            ti[7] = '{3, 0, 3, 3, 0, 0, 0};
    logic [DW-1:0] r; logic [1:0] st; logic [7:0] tg, tag; logic [CW-1:0] it; int lat; bit got;
    for (int i = 0; i < 7; i++) begin
      tag = 8'(i * 17 + 3);
      run_job(ta[i], tp[i], tag, r, st, tg, it, lat, got);
      n_cmp++;
      if (!got || r !== tr[i] || st !== ts[i] || tg !== tag || it !== CW'(ti[i])) begin
        n_bad++;
        $display("FAIL directed_%0d: got v=%0b r=%0d st=%0d tag=%h it=%0d want r=%0d st=%0d tag=%h it=%0d",
                 i, got, r, st, tg, it, tr[i], ts[i], tag, ti[i]);
      end
      // Latency: accept edge + CHECK + (steps+1) RUN cycles, or accept + CHECK for bad input.
      n_cmp++;
      if (lat != ((ts[i] == 2'd2) ? 2 : ti[i] + 3)) begin
        n_bad++; $display("FAIL directed_latency_%0d: got %0d want %0d", i, lat,
                          (ts[i] == 2'd2) ? 2 : ti[i] + 3);
      end
    end
  endtask

  task automatic test_back_pressure();
    int cyc;
    bus.in_a = 256'd3; bus.in_p = 256'd7; bus.in_tag = 8'hA5; bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    tick();
    cyc = 0;
    while (!bus.out_valid && cyc < 100) begin
      bus.in_valid = cyc[0]; bus.in_a = 256'd6; bus.in_p = 256'd9; bus.in_tag = 8'h11;
      tick(); cyc++;
    end
    n_cmp++;
    if (cyc != 5) begin
      n_bad++; $display("FAIL bp_latency: got %0d cycles after accept want 5", cyc);
    end
    for (int k = 0; k < 10; k++) begin
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_r !== 256'd5 || bus.out_status !== 2'd0 ||
          bus.out_tag !== 8'hA5 || bus.out_iters !== CW'(3) || bus.in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_hold_%0d: v=%b r=%0d st=%0d tag=%h it=%0d rdy=%b want 1,5,0,a5,3,0", k,
                 bus.out_valid, bus.out_r, bus.out_status, bus.out_tag, bus.out_iters,
                 bus.in_ready);
      end
      bus.in_valid = k[0];
      tick();
    end
    // Release with a new request already pending: it must not be taken on the release edge.
    bus.in_a = 256'd1; bus.in_p = 256'd7; bus.in_tag = 8'h3C; bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || busy !== 1'b0) begin
      n_bad++; $display("FAIL bp_release: v=%b rdy=%b busy=%b want 0 1 0",
                        bus.out_valid, bus.in_ready, busy);
    end
    tick();
    bus.in_valid = 1'b0;
    cyc = 0;
    while (!bus.out_valid && cyc < 100) begin
      tick(); cyc++;
    end
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_r !== 256'd1 || bus.out_tag !== 8'h3C) begin
      n_bad++; $display("FAIL bp_next_job: v=%b r=%0d tag=%h want 1 1 3c",
                        bus.out_valid, bus.out_r, bus.out_tag);
    end
    bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
  endtask

  task automatic test_abort();
    bit seen;
    int cyc;
    // Abort during RUN.
    bus.in_a = rand256(); bus.in_p = (256'd1 << 255) - 256'd19; bus.in_valid = 1'b1;
    tick(); bus.in_valid = 1'b0;
    repeat (4) tick();
    abort = 1'b1; tick(); abort = 1'b0;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || busy !== 1'b0) begin
      n_bad++; $display("FAIL abort_run: v=%b rdy=%b busy=%b want 0 1 0",
                        bus.out_valid, bus.in_ready, busy);
    end
    seen = 1'b0;
    repeat (30) begin
      if (bus.out_valid) seen = 1'b1;
      tick();
    end
    n_cmp++;
    if (seen || bus.in_ready !== 1'b1) begin
      n_bad++; $display("FAIL abort_run_quiet: valid_seen=%b rdy=%b want 0 1", seen, bus.in_ready);
    end
    // Abort during DONE, together with out_ready.
    bus.in_a = 256'd3; bus.in_p = 256'd7; bus.in_valid = 1'b1;
    tick(); bus.in_valid = 1'b0;
    cyc = 0;
    while (!bus.out_valid && cyc < 100) begin
      tick(); cyc++;
    end
    n_cmp++;
    if (bus.out_valid !== 1'b1) begin
      n_bad++; $display("FAIL abort_done_setup: v=%b want 1", bus.out_valid);
    end
    abort = 1'b1; bus.out_ready = 1'b1; tick(); abort = 1'b0; bus.out_ready = 1'b0;
    tick();
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_bad++; $display("FAIL abort_done: v=%b rdy=%b want 0 1", bus.out_valid, bus.in_ready);
    end
    // Abort in IDLE blocks acceptance.
    bus.in_valid = 1'b1; abort = 1'b1; tick(); abort = 1'b0; bus.in_valid = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_bad++; $display("FAIL abort_idle: busy=%b rdy=%b want 0 1", busy, bus.in_ready);
    end
  endtask

  task automatic test_reset_mid_run();
    bit seen;
    bus.in_a = rand256(); bus.in_p = (256'd1 << 255) - 256'd19; bus.in_tag = 8'h77;
    bus.in_valid = 1'b1;
    tick(); bus.in_valid = 1'b0;
    repeat (5) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    n_cmp++;
    if ({bus.in_ready, bus.out_valid, busy} !== 3'b100 || bus.out_r !== '0 ||
        bus.out_status !== 2'd0 || bus.out_tag !== 8'd0 || bus.out_iters !== '0) begin
      n_bad++; $display("FAIL reset_mid_run: rdy/v/busy=%b r=%h st=%0d tag=%h it=%0d want 100 0 0 0 0",
                        {bus.in_ready, bus.out_valid, busy}, bus.out_r, bus.out_status,
                        bus.out_tag, bus.out_iters);
    end
    seen = 1'b0;
    repeat (30) begin
      if (bus.out_valid) seen = 1'b1;
      tick();
    end
    n_cmp++;
    if (seen) begin
      n_bad++; $display("FAIL reset_mid_run_quiet: valid_seen=1 want 0");
    end
  endtask

  task automatic test_timeout();
    int cyc;
    tbus.in_a = 256'd3; tbus.in_p = (256'd1 << 255) - 256'd19; tbus.in_tag = 8'h5A;
    tbus.in_valid = 1'b1; tbus.out_ready = 1'b0;
    tick(); tbus.in_valid = 1'b0;
    cyc = 0;
    while (!tbus.out_valid && cyc < 100) begin
      tick(); cyc++;
    end
    n_cmp++;
    if (tbus.out_valid !== 1'b1 || tbus.out_status !== 2'd3 || tbus.out_r !== '0 ||
        tbus.out_iters !== 3'd4 || tbus.out_tag !== 8'h5A) begin
      n_bad++; $display("FAIL timeout: v=%b st=%0d r=%0d it=%0d tag=%h want 1 3 0 4 5a",
                        tbus.out_valid, tbus.out_status, tbus.out_r, tbus.out_iters,
                        tbus.out_tag);
    end
    tbus.out_ready = 1'b1; tick(); tbus.out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [DW-1:0] a, p, r, g, q, s; logic [1:0] st; logic [7:0] tg, tag; logic [CW-1:0] it;
    logic [2*DW-1:0] prod;
    int lat, f; bit got, ok;
    int factors[4] = '{3, 5, 7, 11};
    for (int n = 0; n < 48; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        f = factors[$urandom_range(0, 3)];
        q = (rand256() >> 8) | 256'd1;
        s = (rand256() >> 8) | 256'd1;
        p = q * DW'(f);
        a = s * DW'(f);
      end else begin
        p = rand256(); p[0] = 1'b1; p[DW-1] = 1'b1;
        a = rand256() >> $urandom_range(0, 8);
        if (a == '0) a = 256'd1;
      end
      tag = 8'($urandom());
      run_job(a, p, tag, r, st, tg, it, lat, got);
      g = gcd(a, p);
      if (g == 256'd1) begin
        prod = {{DW{1'b0}}, r} * {{DW{1'b0}}, a};
        ok = got && st == 2'd0 && r != '0 && r < p && (prod % {{DW{1'b0}}, p}) == 512'd1;
      end else begin
        ok = got && st == 2'd1 && r == '0;
      end
      n_cmp++;
      if (!ok || tg !== tag) begin
        n_bad++; $display("FAIL random_%0d: a=%h p=%h gcd1=%b got v=%b st=%0d r=%h tag=%h want tag %h",
                          n, a, p, g == 256'd1, got, st, r, tg, tag);
      end
      n_cmp++;
      if (it >= CW'(MaxIter) || lat != int'(it) + 3) begin
        n_bad++; $display("FAIL random_iters_%0d: it=%0d lat=%0d want it<%0d lat=it+3",
                          n, it, lat, MaxIter);
      end
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_p = '0; bus.in_tag = '0; bus.out_ready = 1'b0;
    tbus.in_valid = 1'b0; tbus.in_a = '0; tbus.in_p = '0; tbus.in_tag = '0;
    tbus.out_ready = 1'b0;
    test_reset();
    test_directed();
    test_back_pressure();
    test_abort();
    test_reset_mid_run();
    test_timeout();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: bench exceeded time limit");
    $fatal(1, "time limit");
  end
endmodule
